pipe_scroll_controller: RTL and testbench
=========================================

# pipe_scroll_controller

Sequences the pipe pattern source (32-entry pipe table + LFSR pattern generator) onto the 16×16 LED playfield. It owns the game state machine (idle/play/over) and a scroll timebase. It fetches one 16-bit pipe column per `PIPE_SPACING` scroll steps over a req/ack handshake and shifts the playfield left. It also detects bird/pipe collision and keeps the score. It sits between the pipe generator and the LED driver; the bird-motion block supplies `bird_row`.

## Interface
- `TICK_DIV`, default 12_500_000: clock cycles per scroll step; must be ≥2.
- `PIPE_SPACING`, default 4: scroll steps between successive pipe columns; range 2–15.
- `BIRD_COL`, default 2: playfield column occupied by the bird; range 0–14.
- `clock` in 1: single system clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle key pulse.
  - IDLE→PLAY.
  - OVER→IDLE.
  - Ignored in PLAY.
- `bird_row` in 4: current bird row, 0 = bottom.
- `pipe_req` out 1: request for a new pipe pattern.
- `pipe_ack` in 1: pattern valid this cycle.
- `pipe_pattern` in 16: column bits; 1 = wall lit, 0 = gap.
- `frame` out 256: playfield; bits [16c+15:16c] = column c; column 0 = leftmost.
- `score` out 8: pipes passed, saturating at 255.
- `playing` out 1: state == PLAY.
- `game_over` out 1: state == OVER.

## Operation
- States: IDLE, PLAY, OVER.
  - IDLE + `start` → PLAY. On entry: clear `frame`, `score`, tick counter, spacing counter, pattern buffer and pipe-flag vector.
  - PLAY + collision → OVER.
  - OVER + `start` → IDLE. `frame` and `score` are held in IDLE until the next PLAY entry.
- Tick counter:
  - Counts 0..`TICK_DIV`-1 in PLAY only; frozen at 0 otherwise.
  - `step` = (count == `TICK_DIV`-1) && state == PLAY.
- Pattern buffer (1 entry + valid bit):
  - `pipe_req` = PLAY && !buf_valid.
  - Pattern is latched on `pipe_req && pipe_ack`; buf_valid is set.
  - `pipe_ack` without `pipe_req` is ignored.
- Scroll on `step`:
  - col[i] ← col[i+1] for i = 0..14.
  - flag[i] ← flag[i+1].
  - Column 15 and flag[15] are loaded as follows:
    - If (spacing_cnt == `PIPE_SPACING`-1 or pending) and buf_valid: load the buffered pattern into column 15, set flag[15]=1, clear buf_valid, clear pending, set spacing_cnt=0.
    - Else if spacing_cnt == `PIPE_SPACING`-1 and !buf_valid: load zeros into column 15, set pending=1, set spacing_cnt=0. The pipe lands on the first later step with buf_valid.
    - Else: load zeros into column 15 and increment spacing_cnt.
- Collision: combinational `hit` = PLAY && col[`BIRD_COL`][`bird_row`]. `hit` is evaluated every cycle, not only on step.
- Score: on `step` with !`hit` and flag[`BIRD_COL`]==1, `score` ← min(`score`+1, 255).
- Priority: `hit` overrides `step` in the same cycle. There is no shift and no score update, and the state goes to OVER.

## Timing
- Reset values: state IDLE, `frame`=0, `score`=0, `pipe_req`=0, `playing`=0, `game_over`=0. Tick, spacing, buffer, pending and flags are all 0.
- `pipe_req` rises 1 cycle after PLAY entry. It falls the cycle after the ack beat, and re-rises the cycle after the buffer is consumed.
- `frame`, `score` and state update on the clock edge ending the step/hit cycle. Outputs are registered, except `pipe_req`, `playing` and `game_over`, which decode registered state.
- First step occurs `TICK_DIV` cycles after PLAY entry. Subsequent steps are every `TICK_DIV` cycles.
- A pipe loaded into column 15 reaches `BIRD_COL` after 15-`BIRD_COL` further steps.
- Reset deasserting mid-game returns to IDLE with everything cleared. No partial state survives.

## Structure
- Package `flappy_pkg`:
  - `game_state_t` enum {IDLE, PLAY, OVER}.
  - `ROWS`=16, `COLS`=16.
  - `pattern_t` = logic [15:0].
- One sub-module `scroll_timer`: parameter `TICK_DIV`; ports `clock`, `reset`, `en`, `step`. The counter clears whenever `en`=0.
- Playfield and flags are stored as unpacked arrays; `frame` is a flat concatenation.

## Test plan
1. Reset asserted mid-PLAY with nonzero frame → all outputs 0, state IDLE immediately (asynchronously). After release, `start` is required to play.
2. `TICK_DIV`=4, `PIPE_SPACING`=4; `start`, then ack pattern 16'hFC3F on the first `pipe_req` → column 15 = FC3F at step 4. Column 3 = FC3F at step 16, column 2 at step 17.
3. Same pipe, `bird_row`=7 (gap) held → no collision. `score` becomes 1 on step 18, when the pipe leaves column 2. `pipe_req` re-asserts the cycle after step 4.
4. `bird_row`=0 while FC3F sits in column 2 → OVER on the next edge, `game_over`=1. `frame` is frozen even if a step coincides.
5. Withhold `pipe_ack` through step 4 → column 15 = 0 and pending set. Ack at cycle 18 → the pipe lands at step 5, and the next pipe lands at step 9.
6. Force `score`=254 and pass 3 pipes → `score` saturates at 255. `start` in OVER → IDLE, and the next `start` clears `score` to 0.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy playfield blocks.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  localparam int ROWS = 16;
  localparam int COLS = 16;

  typedef logic [ROWS-1:0] pattern_t;

  // Score counter that sticks at its maximum instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/scroll_timer.sv
// Scroll timebase: pulses step once every TICK_DIV enabled cycles; held at 0 while disabled.
module scroll_timer #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic step
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign step = en && (cnt_q == LAST);

endmodule

// File: rtl/pipe_scroll_controller.sv
// Game sequencer: fetches pipe columns, scrolls the 16x16 playfield, detects collision, keeps score.
module pipe_scroll_controller
  import flappy_pkg::*;
#(
  parameter int TICK_DIV     = 12_500_000,
  parameter int PIPE_SPACING = 4,
  parameter int BIRD_COL     = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   bird_row,
  output logic         pipe_req,
  input  logic         pipe_ack,
  input  logic [15:0]  pipe_pattern,
  output logic [255:0] frame,
  output logic [7:0]   score,
  output logic         playing,
  output logic         game_over
);

  localparam logic [3:0] SPACE_LAST = 4'(PIPE_SPACING - 1);

  game_state_t state_q, state_d;
  pattern_t    col_q  [COLS];
  pattern_t    col_d  [COLS];
  logic        flag_q [COLS];
  logic        flag_d [COLS];
  pattern_t    buf_q, buf_d;
  logic        buf_valid_q, buf_valid_d;
  logic        pending_q, pending_d;
  logic [3:0]  spacing_q, spacing_d;
  logic [7:0]  score_q, score_d;
  logic        step;
  logic        hit;

  scroll_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clock (clock),
    .reset (reset),
    .en    (state_q == PLAY),
    .step  (step)
  );

  // Collision is checked every cycle so a bird moving into a wall is caught between steps.
  assign hit = (state_q == PLAY) && col_q[BIRD_COL][bird_row];

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    pending_d   = pending_q;
    spacing_d   = spacing_q;
    score_d     = score_q;
    for (int i = 0; i < COLS; i++) begin
      col_d[i]  = col_q[i];
      flag_d[i] = flag_q[i];
    end

    unique case (state_q)
      IDLE: begin
        // Playfield and score of the previous game stay visible until a new game starts.
        if (start) begin
          state_d     = PLAY;
          buf_d       = '0;
          buf_valid_d = 1'b0;
          pending_d   = 1'b0;
          spacing_d   = '0;
          score_d     = '0;
          for (int i = 0; i < COLS; i++) begin
            col_d[i]  = '0;
            flag_d[i] = 1'b0;
          end
        end
      end
      PLAY: begin
        if (pipe_req && pipe_ack) begin
          buf_d       = pipe_pattern;
          buf_valid_d = 1'b1;
        end
        if (hit) begin
          state_d = OVER;
        end else if (step) begin
          for (int i = 0; i < COLS - 1; i++) begin
            col_d[i]  = col_q[i+1];
            flag_d[i] = flag_q[i+1];
          end
          // A late pattern lands on the first step after it arrives, restarting the spacing.
          if ((spacing_q == SPACE_LAST || pending_q) && buf_valid_q) begin
            col_d[COLS-1]  = buf_q;
            flag_d[COLS-1] = 1'b1;
            buf_valid_d    = 1'b0;
            pending_d      = 1'b0;
            spacing_d      = '0;
          end else if (spacing_q == SPACE_LAST) begin
            col_d[COLS-1]  = '0;
            flag_d[COLS-1] = 1'b0;
            pending_d      = 1'b1;
            spacing_d      = '0;
          end else begin
            col_d[COLS-1]  = '0;
            flag_d[COLS-1] = 1'b0;
            spacing_d      = spacing_q + 4'd1;
          end
          if (flag_q[BIRD_COL]) begin
            score_d = sat_inc8(score_q);
          end
        end
      end
      OVER: begin
        if (start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      pending_q   <= 1'b0;
      spacing_q   <= '0;
      score_q     <= '0;
      for (int i = 0; i < COLS; i++) begin
        col_q[i]  <= '0;
        flag_q[i] <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      pending_q   <= pending_d;
      spacing_q   <= spacing_d;
      score_q     <= score_d;
      for (int i = 0; i < COLS; i++) begin
        col_q[i]  <= col_d[i];
        flag_q[i] <= flag_d[i];
      end
    end
  end

  always_comb begin
    frame = '0;
    for (int c = 0; c < COLS; c++) begin
      frame[c*ROWS +: ROWS] = col_q[c];
    end
  end

  assign score     = score_q;
  assign pipe_req  = (state_q == PLAY) && !buf_valid_q;
  assign playing   = (state_q == PLAY);
  assign game_over = (state_q == OVER);

endmodule

// File: tb/tb_pipe_scroll_controller.sv
// Directed bench for pipe_scroll_controller with TICK_DIV=4, PIPE_SPACING=4, BIRD_COL=2.
module tb_pipe_scroll_controller;

  localparam int TD = 4;
  localparam logic [15:0] PIPE = 16'hFC3F;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   bird_row = 4'd7;
  logic         pipe_req;
  logic         pipe_ack = 1'b0;
  logic [15:0]  pipe_pattern = PIPE;
  logic [255:0] frame;
  logic [7:0]   score;
  logic         playing;
  logic         game_over;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit ack_en = 1'b0;

  always #5 clock = ~clock;

  pipe_scroll_controller #(
    .TICK_DIV     (TD),
    .PIPE_SPACING (4),
    .BIRD_COL     (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .bird_row     (bird_row),
    .pipe_req     (pipe_req),
    .pipe_ack     (pipe_ack),
    .pipe_pattern (pipe_pattern),
    .frame        (frame),
    .score        (score),
    .playing      (playing),
    .game_over    (game_over)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] col(input int c);
    return frame[16*c +: 16];
  endfunction

  // Pulse start; afterwards we sit on the negedge after the state-change edge (cyc = 0).
  task automatic do_start();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    cyc = 0;
  endtask

  // Advance to the negedge just after scroll step k has been applied.
  task automatic go_step(input int k);
    repeat (k*TD - cyc) @(negedge clock);
    cyc = k*TD;
  endtask

  // Pattern source: acknowledges an outstanding request when enabled.
  initial begin
    forever begin
      @(negedge clock);
      pipe_ack = ack_en && pipe_req;
    end
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    check_eq("rst_frame", {31'd0, |frame}, 0);
    check_eq("rst_score", score, 0);
    check_eq("rst_req", pipe_req, 0);
    check_eq("rst_playing", playing, 0);
    check_eq("rst_over", game_over, 0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("idle_no_req", pipe_req, 0);

    // Normal play, pipe timing and scoring
    ack_en = 1'b1;
    do_start();
    check_eq("entry_playing", playing, 1);
    check_eq("entry_req", pipe_req, 1);
    go_step(3);
    check_eq("s3_col15", col(15), 0);
    go_step(4);
    check_eq("s4_col15", col(15), PIPE);
    check_eq("s4_req_rerise", pipe_req, 1);
    @(negedge clock); cyc++;
    check_eq("s4_req_fall", pipe_req, 0);
    go_step(16);
    check_eq("s16_col3", col(3), PIPE);
    go_step(17);
    check_eq("s17_col2", col(2), PIPE);
    check_eq("s17_score", score, 0);
    go_step(18);
    check_eq("s18_score", score, 1);
    check_eq("s18_col1", col(1), PIPE);
    go_step(21);
    check_eq("s21_col2", col(2), PIPE);

    // Collision in the same cycle as step 22: no shift, no score
    repeat (3) @(negedge clock);
    bird_row = 4'd0;
    @(negedge clock);
    check_eq("hit_over", game_over, 1);
    check_eq("hit_playing", playing, 0);
    check_eq("hit_col2_frozen", col(2), PIPE);
    check_eq("hit_score_frozen", score, 1);
    repeat (8) @(negedge clock);
    check_eq("over_col2_held", col(2), PIPE);
    bird_row = 4'd7;
    do_start();
    check_eq("to_idle_over", game_over, 0);
    check_eq("to_idle_playing", playing, 0);
    check_eq("idle_score_held", score, 1);
    check_eq("idle_col2_held", col(2), PIPE);

    // Asynchronous reset mid-game
    do_start();
    check_eq("restart_score", score, 0);
    check_eq("restart_frame", {31'd0, |frame}, 0);
    go_step(5);
    check_eq("pre_rst_col14", col(14), PIPE);
    #2 reset = 1'b0;
    #1;
    check_eq("arst_frame", {31'd0, |frame}, 0);
    check_eq("arst_playing", playing, 0);
    check_eq("arst_req", pipe_req, 0);
    @(negedge clock) reset = 1'b1;
    repeat (6) @(negedge clock);
    check_eq("post_rst_idle", playing, 0);
    check_eq("post_rst_frame", {31'd0, |frame}, 0);

    // Withheld ack: pending pipe lands on step 5, next on step 9
    ack_en = 1'b0;
    do_start();
    go_step(4);
    check_eq("late_s4_col15", col(15), 0);
    check_eq("late_s4_req", pipe_req, 1);
    repeat (1) @(negedge clock); cyc++;
    ack_en = 1'b1;
    go_step(5);
    check_eq("late_s5_col15", col(15), PIPE);
    go_step(6);
    check_eq("late_s6_col15", col(15), 0);
    check_eq("late_s6_col14", col(14), PIPE);
    go_step(8);
    check_eq("late_s8_col15", col(15), 0);
    go_step(9);
    check_eq("late_s9_col15", col(15), PIPE);

    // Score saturation: pipe n (n>=2) lands at step 4n+1 and scores at step 4n+15
    go_step(1034);
    check_eq("sat_254", score, 254);
    go_step(1035);
    check_eq("sat_255", score, 255);
    go_step(1038);
    check_eq("sat_col2", col(2), PIPE);
    check_eq("sat_hold", score, 255);
    bird_row = 4'd0;
    @(negedge clock);
    check_eq("sat_over", game_over, 1);
    bird_row = 4'd7;
    do_start();
    check_eq("sat_idle_score", score, 255);
    check_eq("sat_idle_state", {30'd0, playing, game_over}, 0);
    do_start();
    check_eq("sat_clear_score", score, 0);
    check_eq("sat_playing", playing, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
